subtractor_9bit_serial: RTL
===========================

// Module: subtractor_9bit_serial
// PURPOSE
//   Bit-serial unsigned subtractor, the inverse of the 9-bit ripple adder. It computes diff = a - b
//   one bit per clock, LSB first, through a single full-subtractor cell.
//   Operands arrive on a valid/ready handshake; the result leaves on a valid/ready handshake.
//   Used in the arithmetic datapath where a 9-bit subtract is needed and area matters more than latency.
// PARAMETERS
//   WIDTH   9   operand width in bits; legal range WIDTH >= 2
// PORTS
//   clk        in   1          single clock, all state updates on rising edge
//   rst_n      in   1          synchronous, active-low reset
//   in_valid   in   1          a/b valid
//   in_ready   out  1          block can accept operands (high only in IDLE)
//   a          in   WIDTH      minuend, unsigned
//   b          in   WIDTH      subtrahend, unsigned
//   out_valid  out  1          diff valid
//   out_ready  in   1          consumer accepts diff
//   diff       out  WIDTH+1    10-bit two's-complement a-b; diff[WIDTH] = final borrow = (a < b)
// BEHAVIOUR
//   - Reset: synchronous, active-low. While rst_n=0 at a rising edge: state<=IDLE, out_valid<=0,
//     diff<=0, and the shift registers, borrow and count are cleared.
//   - Values after reset: in_ready=1, out_valid=0, diff=0.
//   - FSM: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: in_ready=1. If in_valid=1, latch a->sh_a and b->sh_b, set borrow<=0 and cnt<=0, go to RUN.
//     RUN: in_ready=0. Each cycle, subtractor_1bit(sh_a[0], sh_b[0], borrow) produces d and bout.
//       d shifts into res from the MSB side; sh_a and sh_b shift right; borrow<=bout; cnt<=cnt+1.
//       When cnt==WIDTH-1, go to DONE and register diff<={bout, d, res[WIDTH-1:1]}.
//     DONE: out_valid=1 and diff is held stable. If out_ready=1, go to IDLE (out_valid<=0);
//       otherwise hold indefinitely.
//   - Latency:
//     * Operands accepted at edge k; out_valid is first high after edge k+WIDTH (9 cycles for the default).
//     * Minimum issue interval is WIDTH+2 cycles; there is no overlap of operations.
//   - Arithmetic:
//     * Full subtractor: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
//     * Result is exact over the full range: -511..+511 in 10-bit two's complement.
//   - Boundaries:
//     * in_valid during RUN or DONE is ignored, and a/b are not sampled.
//     * a==b gives diff=0. a=0, b=2^WIDTH-1 gives diff = -(2^WIDTH-1).
//     * diff does not change while out_valid=1 and out_ready=0.
//     * out_ready is ignored when out_valid=0.
//     * Reset mid-RUN or mid-DONE aborts the operation; the result is discarded and no out_valid pulse occurs.
//   - diff and out_valid are registered outputs. in_ready is decoded from the state register.
// STRUCTURE
//   - Shared package cella_arith_pkg holds:
//     * state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
//     * default operand width ARITH_W=9;
//     * counter width $clog2(ARITH_W).
//   - One sub-module, subtractor_1bit (a, b, bin -> diff, bout). It is the bit-level counterpart
//     of adder_1bit and is instantiated once.
//   - Top level contains the FSM, the sh_a/sh_b/res shift registers, the borrow flop and the bit counter.
// TESTING
//   1. a=300, b=45 -> diff=10'd255, diff[9]=0; out_valid rises 9 cycles after the accept edge.
//   2. a=0, b=1 -> diff=10'h3FF. a=10, b=20 -> diff=10'h3F6 (-10).
//   3. a=511, b=511 -> diff=0. a=511, b=0 -> diff=10'd511. a=0, b=511 -> diff=10'h201.
//   4. Backpressure: result ready, out_ready=0 for 5 cycles, then 1.
//      -> diff and out_valid hold steady; in_ready=0 throughout.
//      -> a new in_valid with a=7, b=3 in that window is ignored; the next accept happens only after return to IDLE.
//   5. Reset: rst_n=0 for 1 cycle at RUN cycle 4 of a=100, b=1.
//      -> next cycle: out_valid=0, diff=0, in_ready=1.
//      -> a following a=20, b=10 gives diff=10 with no stale result.
//   6. Random regression: 1000 random a/b pairs with random in_valid/out_ready.
//      -> every diff equals (a - b) mod 2^10, in issue order, with no lost or duplicated results.

Source files
------------

// File: rtl/cella_arith_pkg.sv
// Shared arithmetic-datapath definitions.
// FSM encoding, default operand width and counter width.
package cella_arith_pkg;

  localparam int ARITH_W = 9;
  localparam int CNT_W   = $clog2(ARITH_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/subtractor_9bit_serial_if.sv
// Operand/result valid-ready bundle for the serial subtractor.
// slave is the subtractor side, master the producer/consumer side.
interface subtractor_9bit_serial_if
  import cella_arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   diff;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff
  );

endinterface

// File: rtl/subtractor_1bit.sv
// Single full-subtractor cell, bit-level counterpart of adder_1bit.
// diff = a - b - bin, bout set when a borrow is needed.
module subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtractor_9bit_serial.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Result is a WIDTH+1 bit two's-complement a - b.
module subtractor_9bit_serial
  import cella_arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  subtractor_9bit_serial_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   diff_q, diff_d;

  logic d_bit;
  logic bout;

  subtractor_1bit u_cell (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .bin  (borrow_q),
    .diff (d_bit),
    .bout (bout)
  );

  always_comb begin
    state_d     = state_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    res_d       = res_q;
    borrow_d    = borrow_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sh_a_d   = bus.a;
          sh_b_d   = bus.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        sh_a_d   = sh_a_q >> 1;
        sh_b_d   = sh_b_q >> 1;
        // res keeps the low WIDTH-1 result bits; the last bit and borrow join at the end
        res_d    = (WIDTH-1)'({d_bit, res_q} >> 1);
        borrow_d = bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d      = {bout, d_bit, res_q};
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      res_q       <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
    end else begin
      state_q     <= state_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      res_q       <= res_d;
      borrow_q    <= borrow_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;

endmodule
